// File: rtl/iterative_alu.sv
// -----------------------------------------------------------------------------
// iterative_alu
//
// Execute-stage ALU. It takes a 4-bit ALU control code and two operands and
// returns a registered result. Arithmetic and logic ops finish in one cycle.
// Shifts go through a serial shifter that moves one bit per cycle, so a shift
// by N takes N cycles in the SHIFT state. The start/ready/done handshake lets
// the controller stall while a shift is in flight. kill aborts an in-flight op
// when the pipeline is redirected.
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   rst          synchronous, active-high reset
//   start        request; accepted only when ready=1 and kill=0
//   alu_control  op code: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR,
//                6 SRL, 7 SRA, 8 OR, 9 AND; codes 10-15 give result 0
//   src_a        operand A
//   src_b        operand B; shifts use only the low log2(WIDTH) bits
//   kill         abort any in-flight op; result keeps its previous value
//   ready        high in IDLE and DONE
//   done         one-cycle pulse; result is valid in that cycle
//   result       registered result, held until the next done or reset
//   zero         high when result is 0
// -----------------------------------------------------------------------------
module iterative_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             kill,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [3:0]       op_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [SHW-1:0]   count_reg;
    logic [WIDTH-1:0] result_reg;
    logic             done_reg;
    logic             ready_reg;

    // ------------------------------------------------------------------
    // Single-cycle datapath, evaluated on the live inputs in the accept
    // cycle. Its output is written straight into result_reg, so later
    // changes to the operands have no effect.
    // ------------------------------------------------------------------
    logic [SHW-1:0]   shamt;
    logic             is_shift;
    logic [WIDTH-1:0] alu_value;

    assign shamt    = src_b[SHW-1:0];
    assign is_shift = (alu_control == OP_SLL) || (alu_control == OP_SRL) ||
                      (alu_control == OP_SRA);

    always_comb begin
        alu_value = '0;
        case (alu_control)
            OP_ADD:  alu_value = src_a + src_b;
            OP_SUB:  alu_value = src_a - src_b;
            OP_SLT:  alu_value[0] = ($signed(src_a) < $signed(src_b));
            OP_SLTU: alu_value[0] = (src_a < src_b);
            OP_XOR:  alu_value = src_a ^ src_b;
            OP_OR:   alu_value = src_a | src_b;
            OP_AND:  alu_value = src_a & src_b;
            // A shift by zero returns the operand unchanged and skips SHIFT.
            OP_SLL, OP_SRL, OP_SRA: alu_value = src_a;
            default: alu_value = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // One-bit serial shifter. Left and right neighbours are wired bit by
    // bit. SRA feeds the current MSB back in, and SRL feeds in 0.
    // ------------------------------------------------------------------
    logic             fill_bit;
    logic [WIDTH-1:0] shl_next;
    logic [WIDTH-1:0] shr_next;
    logic [WIDTH-1:0] shift_next;

    assign fill_bit = (op_reg == OP_SRA) ? shift_reg[WIDTH-1] : 1'b0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == 0) begin : g_lsb
                assign shl_next[gi] = 1'b0;
            end else begin : g_lmid
                assign shl_next[gi] = shift_reg[gi-1];
            end
            if (gi == WIDTH - 1) begin : g_msb
                assign shr_next[gi] = fill_bit;
            end else begin : g_rmid
                assign shr_next[gi] = shift_reg[gi+1];
            end
        end
    endgenerate

    assign shift_next = (op_reg == OP_SLL) ? shl_next : shr_next;

    // ------------------------------------------------------------------
    // Control FSM with registered done/ready.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            op_reg     <= '0;
            shift_reg  <= '0;
            count_reg  <= '0;
            result_reg <= '0;
            done_reg   <= 1'b0;
            ready_reg  <= 1'b1;
        end else if (kill) begin
            // The abort drops any in-flight op and blocks a new start in the
            // same cycle. result_reg is left unchanged on purpose.
            state_reg <= ST_IDLE;
            done_reg  <= 1'b0;
            ready_reg <= 1'b1;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    // DONE accepts a new op just as IDLE does, so ops can
                    // run back to back.
                    if (start) begin
                        op_reg <= alu_control;
                        if (is_shift && (shamt != '0)) begin
                            shift_reg <= src_a;
                            count_reg <= shamt;
                            state_reg <= ST_SHIFT;
                            ready_reg <= 1'b0;
                        end else begin
                            result_reg <= alu_value;
                            state_reg  <= ST_DONE;
                            done_reg   <= 1'b1;
                            ready_reg  <= 1'b1;
                        end
                    end else begin
                        state_reg <= ST_IDLE;
                        ready_reg <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    shift_reg <= shift_next;
                    count_reg <= count_reg - SHW'(1);
                    // The last step writes the freshly shifted value
                    // directly, so no extra cycle is spent copying it.
                    if (count_reg == SHW'(1)) begin
                        result_reg <= shift_next;
                        state_reg  <= ST_DONE;
                        done_reg   <= 1'b1;
                        ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign ready  = ready_reg;
    assign done   = done_reg;
    assign result = result_reg;
    assign zero   = (result_reg == '0);

endmodule

// File: tb/tb_iterative_alu.sv
// -----------------------------------------------------------------------------
// tb_iterative_alu
//
// Directed testbench for iterative_alu. It runs a linear sequence of steps
// and compares each result against a hand-computed value.
// -----------------------------------------------------------------------------
module tb_iterative_alu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  alu_control;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        kill;
    logic        ready;
    logic        done;
    logic [31:0] result;
    logic        zero;

    int checks   = 0;
    int failures = 0;

    iterative_alu #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .kill        (kill),
        .ready       (ready),
        .done        (done),
        .result      (result),
        .zero        (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Present a request before a rising edge. When the task returns it is
    // #1 after the accept edge, which is cycle 1. The operands are scrambled
    // at that point because only the latched values may be used.
    task automatic launch(input logic [3:0] ctl, input logic [31:0] a,
                          input logic [31:0] b);
        @(negedge clk);
        start       = 1'b1;
        alu_control = ctl;
        src_a       = a;
        src_b       = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        src_a = $urandom;
        src_b = $urandom;
    endtask

    // Step cycle by cycle until done rises or the budget runs out. lat is
    // the cycle number, counted from the accept cycle, in which done is seen.
    task automatic wait_done(input int base, output int lat);
        lat = base;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] ctl,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [31:0] exp_res);
        int lat;
        launch(ctl, a, b);
        wait_done(1, lat);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, result, exp_res);
        check({tag, "_ready_at_done"}, {31'd0, ready}, 32'd1);
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, (exp_res == 32'd0)});
    endtask

    initial begin
        int lat;
        int seen;

        rst = 1'b1;
        start = 1'b0;
        kill = 1'b0;
        alu_control = 4'd0;
        src_a = '0;
        src_b = '0;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check("reset_done",   {31'd0, done},  32'd0);
        check("reset_ready",  {31'd0, ready}, 32'd1);
        check("reset_result", result,         32'd0);
        check("reset_zero",   {31'd0, zero},  32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Single-cycle ops
        run_op("add_wrap", 4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1, 32'h8000_0000);
        run_op("sub_zero", 4'd1, 32'd5, 32'd5, 1, 32'd0);
        run_op("slt",      4'd3, 32'hFFFF_FFFF, 32'd1, 1, 32'd1);
        run_op("sltu",     4'd4, 32'hFFFF_FFFF, 32'd1, 1, 32'd0);
        run_op("xor",      4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'h0FF0_0FF0);
        run_op("or",       4'd8, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'hFFF0_FFF0);
        run_op("and",      4'd9, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'hF000_F000);
        run_op("sub_neg",  4'd1, 32'd3, 32'd5, 1, 32'hFFFF_FFFE);
        run_op("null10",   4'd10, 32'd5, 32'd6, 1, 32'd0);
        run_op("null15",   4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'd0);

        // Serial shifts
        run_op("sra4",     4'd7, 32'h8000_0000, 32'd4, 5, 32'hF800_0000);
        run_op("srl4",     4'd6, 32'h8000_0000, 32'd4, 5, 32'h0800_0000);
        run_op("sll31",    4'd2, 32'h0000_0001, 32'd31, 32, 32'h8000_0000);
        run_op("sll_sh0",  4'd2, 32'h0000_1234, 32'h0000_0020, 1, 32'h0000_1234);
        run_op("sra_pos3", 4'd7, 32'h4000_0000, 32'd3, 4, 32'h0800_0000);

        // ready stays low for every SHIFT cycle
        launch(4'd6, 32'hFFFF_FFFF, 32'd3);
        check("srl3_ready_c1", {31'd0, ready}, 32'd0);
        @(posedge clk); #1;
        check("srl3_ready_c2", {31'd0, ready}, 32'd0);
        wait_done(2, lat);
        check("srl3_latency", 32'(lat), 32'd4);
        check("srl3_result", result, 32'h1FFF_FFFF);

        // A start pulse during SHIFT is ignored
        launch(4'd2, 32'd3, 32'd8);
        @(negedge clk);
        start = 1'b1; alu_control = 4'd0; src_a = 32'd100; src_b = 32'd100;
        @(posedge clk); #1;
        start = 1'b0;
        check("ignored_start_ready", {31'd0, ready}, 32'd0);
        wait_done(2, lat);
        check("ignored_start_latency", 32'(lat), 32'd9);
        check("ignored_start_result", result, 32'h0000_0300);
        @(posedge clk); #1;
        check("ignored_start_no_2nd_done", {31'd0, done}, 32'd0);

        // Back-to-back: start held through the DONE cycle
        launch(4'd0, 32'd1, 32'd2);
        start = 1'b1; alu_control = 4'd0; src_a = 32'd10; src_b = 32'd20;
        check("b2b_first_done", {31'd0, done}, 32'd1);
        check("b2b_first_result", result, 32'd3);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_second_done", {31'd0, done}, 32'd1);
        check("b2b_second_result", result, 32'd30);
        @(posedge clk); #1;
        check("b2b_done_drops", {31'd0, done}, 32'd0);

        // Kill mid-shift: SLL 1 by 10, with kill raised in cycle 3
        launch(4'd2, 32'd1, 32'd10);
        @(posedge clk); #1;
        @(posedge clk); #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_ready", {31'd0, ready}, 32'd1);
        check("kill_done", {31'd0, done}, 32'd0);
        check("kill_result_kept", result, 32'd30);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("kill_no_late_done", 32'(seen), 32'd0);

        // kill and start in the same cycle: start is not accepted
        @(negedge clk);
        start = 1'b1; kill = 1'b1; alu_control = 4'd0; src_a = 32'd1; src_b = 32'd1;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        check("kill_start_done", {31'd0, done}, 32'd0);
        check("kill_start_result", result, 32'd30);
        @(posedge clk); #1;
        check("kill_start_done_later", {31'd0, done}, 32'd0);

        // A kill in the DONE cycle leaves the current done asserted
        launch(4'd0, 32'd4, 32'd4);
        kill = 1'b1;
        check("kill_in_done_done", {31'd0, done}, 32'd1);
        check("kill_in_done_result", result, 32'd8);
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_in_done_drop", {31'd0, done}, 32'd0);
        check("kill_in_done_result_kept", result, 32'd8);

        // Reset mid-shift
        launch(4'd6, 32'hFFFF_0000, 32'd20);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_done",   {31'd0, done},  32'd0);
        check("rst_mid_ready",  {31'd0, ready}, 32'd1);
        check("rst_mid_result", result,         32'd0);
        check("rst_mid_zero",   {31'd0, zero},  32'd1);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("rst_mid_no_done", 32'(seen), 32'd0);
        run_op("add_after_rst", 4'd0, 32'd2, 32'd3, 1, 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
